// File: rtl/msk_colbuf_pkg.sv
// Shared types and constants for the masked column buffer.
// Share layout helper: bit j, share i of a column sits at index j*d+i.
package msk_colbuf_pkg;

    localparam int COLS     = 4;
    localparam int COL_BITS = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } colbuf_state_t;

    function automatic int share_idx(input int j, input int i, input int d);
        return j * d + i;
    endfunction

endpackage

// File: rtl/MSKmux.sv
// Masked multiplexer gadget: share-wise select driven by a non-sensitive control bit.
// Shares are routed independently, never combined with each other.
module MSKmux #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic                 sel,
    input  logic [count*d-1:0]   in_true,
    input  logic [count*d-1:0]   in_false,
    output logic [count*d-1:0]   out
);

    assign out = sel ? in_true : in_false;

endmodule

// File: rtl/msk_colbuf_ctrl.sv
// Control FSM for msk_column_buffer: state, 2-bit column counter and register selects.
// MSK_COLBUF_CLEAR_EN adds a clear select (reset, flush, final drain handshake).
module msk_colbuf_ctrl
    import msk_colbuf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_in_valid,
    input  logic i_out_ready,
    input  logic i_rot,
    output logic o_in_ready,
    output logic o_out_valid,
    output logic o_busy,
    output logic o_sel_adv,
    output logic o_sel_in
`ifdef MSK_COLBUF_CLEAR_EN
    ,
    output logic o_sel_clr
`endif
);

    colbuf_state_t r_state;
    colbuf_state_t w_state_next;
    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_next;
    logic          w_adv;
    logic          w_in;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_state <= ST_EMPTY;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // w_adv shifts every register along the chain; w_in picks in_col over c0 for c3.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_adv        = 1'b0;
        w_in         = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (i_in_valid) begin
                    w_state_next = ST_FILL;
                    w_cnt_next   = 2'd1;
                    w_adv        = 1'b1;
                    w_in         = 1'b1;
                end
            end
            ST_FILL: begin
                if (i_in_valid) begin
                    w_adv      = 1'b1;
                    w_in       = 1'b1;
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = ST_FULL;
                        w_cnt_next   = 2'd0;
                    end
                end
            end
            ST_FULL: begin
                if (i_out_ready) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = 2'd1;
                    w_adv        = 1'b1;
                end else if (i_rot) begin
                    w_adv = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (i_out_ready) begin
                    w_adv      = 1'b1;
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = ST_EMPTY;
                        w_cnt_next   = 2'd0;
                    end
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    assign o_sel_adv   = w_adv & rst_n & ~i_flush;
    assign o_sel_in    = w_in;
    assign o_in_ready  = (r_state == ST_EMPTY) || (r_state == ST_FILL);
    assign o_out_valid = (r_state == ST_FULL) || (r_state == ST_DRAIN);
    assign o_busy      = (r_state != ST_EMPTY);

`ifdef MSK_COLBUF_CLEAR_EN
    assign o_sel_clr = ~rst_n | i_flush |
                       ((r_state == ST_DRAIN) && (r_cnt == 2'd3) && i_out_ready);
`endif

endmodule

// File: rtl/msk_column_buffer.sv
// Masked 4-column state buffer: loads columns serially, optionally rotates, replays c0 first.
// Optional MSK_COLBUF_CLEAR_EN zeroes all shares on reset, flush and the final drain.
module msk_column_buffer
    import msk_colbuf_pkg::*;
#(
    parameter int d    = 2,
    parameter int COLS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [COL_BITS*d-1:0] in_col,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rot,
    output logic [COL_BITS*d-1:0] out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int W = COL_BITS * d;

    logic w_sel_adv;
    logic w_sel_in;
`ifdef MSK_COLBUF_CLEAR_EN
    logic         w_sel_clr;
    logic [W-1:0] w_zero;
    assign w_zero = '0;
`endif

    msk_colbuf_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .i_rot       (rot),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_sel_adv   (w_sel_adv),
        .o_sel_in    (w_sel_in)
`ifdef MSK_COLBUF_CLEAR_EN
        ,
        .o_sel_clr   (w_sel_clr)
`endif
    );

    // Loading, rotation and draining all move ck <= c(k+1); only c3's source differs.
    genvar gi;
    generate
        for (gi = 0; gi < msk_colbuf_pkg::COLS; gi++) begin : g_col
            logic [W-1:0] r_c;
            logic [W-1:0] w_src;
            logic [W-1:0] w_adv;
            logic [W-1:0] w_next;

            if (gi == msk_colbuf_pkg::COLS - 1) begin : g_tail
                MSKmux #(.d(d), .count(COL_BITS)) u_src_mux (
                    .sel      (w_sel_in),
                    .in_true  (in_col),
                    .in_false (g_col[0].r_c),
                    .out      (w_src)
                );
            end else begin : g_body
                assign w_src = g_col[gi+1].r_c;
            end

            MSKmux #(.d(d), .count(COL_BITS)) u_adv_mux (
                .sel      (w_sel_adv),
                .in_true  (w_src),
                .in_false (r_c),
                .out      (w_adv)
            );

`ifdef MSK_COLBUF_CLEAR_EN
            MSKmux #(.d(d), .count(COL_BITS)) u_clr_mux (
                .sel      (w_sel_clr),
                .in_true  (w_zero),
                .in_false (w_adv),
                .out      (w_next)
            );
`else
            assign w_next = w_adv;
`endif

            always_ff @(posedge clk) begin
                r_c <= w_next;
            end
        end
    endgenerate

    assign out_col = g_col[0].r_c;

    a_cols_fixed: assert property (@(posedge clk) COLS == msk_colbuf_pkg::COLS);

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !rot && !flush) |=> $stable(out_col));

endmodule
